// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED trail PWM display stage.
// Also imported by the testbench so both sides use the same one-hot test.
package led_trail_pkg;

  localparam int DEF_PWM_BITS = 4;
  localparam int DEF_DECAY    = 4;
  localparam int DEF_MAX      = (1 << DEF_PWM_BITS) - 1;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// Port bundle between the position counter, the trail display and the LED pins.
// Also carries read-only debug views of the PWM counter and the per-LED levels.
interface led_trail_pwm_if
  import led_trail_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
);

  // step is a single-cycle strobe with no ready: the slave samples pos on every
  // rising edge where step=1 and always accepts it, so back-to-back strobes are legal.
  logic [7:0]                 pos;
  logic                       step;
  logic [7:0]                 led;
  logic                       dir;
  logic                       pos_err;
  logic [PWM_BITS-1:0]        dbg_pwm_cnt;
  logic [7:0][PWM_BITS-1:0]   dbg_level;

  modport master (
    output pos, step,
    input  led, dir, pos_err, dbg_pwm_cnt, dbg_level
  );

  modport slave (
    input  pos, step,
    output led, dir, pos_err, dbg_pwm_cnt, dbg_level
  );

endinterface

// File: rtl/led_trail_pwm_cell.sv
// One LED of the trail: brightness register with saturating decay, and the
// PWM comparator feeding a registered LED output.
module trail_cell
  import led_trail_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int DECAY    = DEF_DECAY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                decay_en,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX_LVL = '1;
  localparam logic [PWM_BITS-1:0] DEC     = PWM_BITS'(DECAY);

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (load) begin
        level <= MAX_LVL;
      end else if (decay_en) begin
        level <= (level > DEC) ? (level - DEC) : '0;
      end
      // Compares the current level, so a new level shows up one edge later.
      led <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_trail_pwm.sv
// Turns the one-hot bouncing position into eight PWM LEDs with a fading trail,
// tracks sweep direction and latches a sticky error on malformed positions.
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int DECAY    = DEF_DECAY
) (
  input  logic            clk,
  input  logic            reset,
  led_trail_pwm_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] MAX_LVL = '1;

  logic [PWM_BITS-1:0]       pwm_cnt;
  logic [7:0]                prev_pos;
  logic                      dir;
  logic                      pos_err;
  logic                      onehot;
  logic                      valid;
  logic [7:0]                load;
  logic [7:0]                decay_en;
  logic [7:0]                led_w;
  logic [7:0][PWM_BITS-1:0]  lvl;

  // Free-running period of MAX_LVL cycles: counts 0..MAX_LVL-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == MAX_LVL - 1'b1) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_comb begin
    onehot   = is_onehot8(bus.pos);
    valid    = bus.step & onehot;
    load     = valid ? bus.pos : 8'h00;
    decay_en = bus.step ? ~load : 8'h00;
  end

  // A repeated or jumping position leaves dir unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pos <= 8'h01;
      dir      <= 1'b1;
      pos_err  <= 1'b0;
    end else begin
      if (valid) begin
        if (bus.pos == (prev_pos << 1)) begin
          dir <= 1'b1;
        end else if (bus.pos == (prev_pos >> 1)) begin
          dir <= 1'b0;
        end
        prev_pos <= bus.pos;
      end
      if (bus.step && !onehot) begin
        pos_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_cell
    trail_cell #(
      .PWM_BITS (PWM_BITS),
      .DECAY    (DECAY)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .decay_en (decay_en[i]),
      .pwm_cnt  (pwm_cnt),
      .level    (lvl[i]),
      .led      (led_w[i])
    );
  end

  assign bus.led         = led_w;
  assign bus.dir         = dir;
  assign bus.pos_err     = pos_err;
  assign bus.dbg_pwm_cnt = pwm_cnt;
  assign bus.dbg_level   = lvl;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: a vector table for level/dir/pos_err updates
// plus hand-written sequences for reset, PWM duty and reset/step collision.
module tb_led_trail_pwm;
  import led_trail_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  led_trail_pwm_if bus ();

  led_trail_pwm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        step;
    logic [7:0]  pos;
    logic [31:0] lvl;   // nibble i = expected level of LED i
    logic        dir;
    logic        err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.step = 1'b0;
    bus.pos  = 8'h01;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_step(input logic [7:0] p);
    bus.step = 1'b1;
    bus.pos  = p;
    tick();
    bus.step = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    int c0, c1, c2, cx;

    vecs[0]  = '{1'b1, 8'h01, 32'h0000000F, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'h02, 32'h000000FB, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h04, 32'h00000FB7, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h08, 32'h00000FB7, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h08, 32'h0000FB73, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h08, 32'h0000F730, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h08, 32'h0000F300, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h08, 32'h0000F000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h03, 32'h0000B000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h00, 32'h00007000, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h03, 32'h00007000, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 8'h40, 32'h0F003000, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 8'h80, 32'hFB000000, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 8'h40, 32'hBF000000, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 8'h40, 32'h7F000000, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 8'h20, 32'h3BF00000, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 8'h40, 32'h0FB00000, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 8'h20, 32'h0BF00000, 1'b0, 1'b1};

    // Reset and idle: counter wraps 14 -> 0, outputs stay at reset values.
    do_reset();
    chk("rst_led", 32'(bus.led), 32'h00);
    chk("rst_dir", 32'(bus.dir), 32'h1);
    chk("rst_err", 32'(bus.pos_err), 32'h0);
    chk("rst_pwm", 32'(bus.dbg_pwm_cnt), 32'h0);
    chk("rst_lvl", 32'(bus.dbg_level), 32'h0);
    exp_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      exp_cnt = (exp_cnt == 14) ? 0 : exp_cnt + 1;
      chk("idle_pwm", 32'(bus.dbg_pwm_cnt), 32'(exp_cnt));
      chk("idle_led", 32'(bus.led), 32'h00);
    end

    // Single step: one cycle of latency, then led[0] lit for a whole period.
    do_step(8'h01);
    chk("step_latency_led", 32'(bus.led), 32'h00);
    c0 = 0; cx = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      c0 += int'(bus.led[0]);
      cx += int'(bus.led[7:1] != 7'h00);
    end
    chk("single_led0_on", 32'(c0), 32'd15);
    chk("single_others_on", 32'(cx), 32'd0);

    // Trail: back-to-back steps give duty 7/11/15 on bits 0/1/2.
    do_reset();
    do_step(8'h01);
    do_step(8'h02);
    do_step(8'h04);
    c0 = 0; c1 = 0; c2 = 0; cx = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      c0 += int'(bus.led[0]);
      c1 += int'(bus.led[1]);
      c2 += int'(bus.led[2]);
      cx += int'(bus.led[7:3] != 5'h00);
    end
    chk("trail_led0_on", 32'(c0), 32'd7);
    chk("trail_led1_on", 32'(c1), 32'd11);
    chk("trail_led2_on", 32'(c2), 32'd15);
    chk("trail_others_on", 32'(cx), 32'd0);

    // Table: decay saturation, invalid input, direction tracking.
    do_reset();
    for (int v = 0; v < 18; v++) begin
      bus.step = vecs[v].step;
      bus.pos  = vecs[v].pos;
      tick();
      chk($sformatf("vec%0d_lvl", v), 32'(bus.dbg_level), vecs[v].lvl);
      chk($sformatf("vec%0d_dir", v), 32'(bus.dir), 32'(vecs[v].dir));
      chk($sformatf("vec%0d_err", v), 32'(bus.pos_err), 32'(vecs[v].err));
    end
    bus.step = 1'b0;

    // Reset colliding with a step mid-period: reset wins.
    tick();
    tick();
    reset    = 1'b1;
    bus.step = 1'b1;
    bus.pos  = 8'h10;
    tick();
    chk("coll_lvl", 32'(bus.dbg_level), 32'h0);
    chk("coll_led", 32'(bus.led), 32'h00);
    chk("coll_pwm", 32'(bus.dbg_pwm_cnt), 32'h0);
    chk("coll_dir", 32'(bus.dir), 32'h1);
    chk("coll_err", 32'(bus.pos_err), 32'h0);
    reset    = 1'b0;
    bus.step = 1'b0;
    tick();
    chk("post_coll_pwm", 32'(bus.dbg_pwm_cnt), 32'h1);
    chk("post_coll_lvl", 32'(bus.dbg_level), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
